// File: rtl/ascon_ctrl_fsm.sv
// Control sequencer for a one-round-per-clock ASCON-128 encryption datapath.
// Walks init, AD, plaintext and finalisation permutations; drives round index, enables and XOR operands.
module ascon_ctrl_fsm #(
  parameter int unsigned NB_AD_BLOCKS = 1,
  parameter int unsigned NB_PT_BLOCKS = 3
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [63:0]  block_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  output logic         select_o,
  output logic [3:0]   roundp_o,
  output logic         ena_reg_o,
  output logic         ena_xor_up_o,
  output logic [63:0]  data_xor_up_o,
  output logic         ena_xor_down_o,
  output logic [255:0] data_xor_down_o,
  output logic         ena_cipher_o,
  output logic         tag_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned RW    = 4;
  localparam int unsigned BW    = 64;
  localparam int unsigned KW    = 128;
  localparam int unsigned DW    = 256;
  localparam int unsigned AD_CW = $clog2(NB_AD_BLOCKS + 1);
  localparam int unsigned PT_CW = $clog2(NB_PT_BLOCKS + 1);

  localparam logic [RW-1:0] ROUND_FIRST_A = RW'(0);
  localparam logic [RW-1:0] ROUND_FIRST_B = RW'(6);
  localparam logic [RW-1:0] ROUND_LAST    = RW'(11);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [AD_CW-1:0] ad_cnt_q, ad_cnt_d;
  logic [PT_CW-1:0] pt_cnt_q, pt_cnt_d;
  logic [KW-1:0]    key_q, key_d;

  logic last_ad_done;
  logic last_pt_next;

  // last_pt_next: the next plaintext block to arrive is the final one
  assign last_ad_done = (ad_cnt_q == AD_CW'(NB_AD_BLOCKS));
  assign last_pt_next = (pt_cnt_q == PT_CW'(NB_PT_BLOCKS - 1));

  // State and counter registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      ad_cnt_q <= '0;
      pt_cnt_q <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
      key_q    <= key_d;
    end
  end

  // Next-state and Mealy control outputs
  always_comb begin
    state_d         = state_q;
    rcnt_d          = rcnt_q;
    ad_cnt_d        = ad_cnt_q;
    pt_cnt_d        = pt_cnt_q;
    key_d           = key_q;
    block_ready_o   = 1'b0;
    select_o        = 1'b0;
    roundp_o        = '0;
    ena_reg_o       = 1'b0;
    ena_xor_up_o    = 1'b0;
    data_xor_up_o   = '0;
    ena_xor_down_o  = 1'b0;
    data_xor_down_o = '0;
    ena_cipher_o    = 1'b0;
    tag_valid_o     = 1'b0;
    busy_o          = (state_q != IDLE);
    done_o          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          select_o  = 1'b1;
          roundp_o  = ROUND_FIRST_A;
          ena_reg_o = 1'b1;
          key_d     = key_i;
          rcnt_d    = RW'(1);
          state_d   = INIT;
        end
      end

      INIT, FINAL: begin
        roundp_o  = rcnt_q;
        ena_reg_o = 1'b1;
        rcnt_d    = rcnt_q + RW'(1);
        if (rcnt_q == ROUND_LAST) begin
          ena_xor_down_o  = 1'b1;
          data_xor_down_o = {(DW - KW)'(0), key_q};
          rcnt_d          = '0;
          if (state_q == INIT) begin
            state_d = WAIT_AD;
          end else begin
            ad_cnt_d = '0;
            pt_cnt_d = '0;
            state_d  = DONE;
          end
        end
      end

      WAIT_AD: begin
        block_ready_o = 1'b1;
        if (block_valid_i) begin
          ena_reg_o     = 1'b1;
          ena_xor_up_o  = 1'b1;
          data_xor_up_o = block_i;
          roundp_o      = ROUND_FIRST_B;
          ad_cnt_d      = ad_cnt_q + AD_CW'(1);
          rcnt_d        = ROUND_FIRST_B + RW'(1);
          state_d       = AD;
        end
      end

      AD: begin
        roundp_o  = rcnt_q;
        ena_reg_o = 1'b1;
        rcnt_d    = rcnt_q + RW'(1);
        if (rcnt_q == ROUND_LAST) begin
          rcnt_d = '0;
          if (last_ad_done) begin
            // Domain separation, merged with the key pre-XOR when only one PT block exists
            ena_xor_down_o  = 1'b1;
            data_xor_down_o = {(last_pt_next ? key_q : KW'(0)), BW'(0), BW'(1)};
            state_d         = WAIT_PT;
          end else begin
            state_d = WAIT_AD;
          end
        end
      end

      WAIT_PT: begin
        block_ready_o = 1'b1;
        if (block_valid_i) begin
          ena_reg_o     = 1'b1;
          ena_xor_up_o  = 1'b1;
          data_xor_up_o = block_i;
          ena_cipher_o  = 1'b1;
          pt_cnt_d      = pt_cnt_q + PT_CW'(1);
          if (last_pt_next) begin
            roundp_o = ROUND_FIRST_A;
            rcnt_d   = RW'(1);
            state_d  = FINAL;
          end else begin
            roundp_o = ROUND_FIRST_B;
            rcnt_d   = ROUND_FIRST_B + RW'(1);
            state_d  = PT;
          end
        end
      end

      PT: begin
        roundp_o  = rcnt_q;
        ena_reg_o = 1'b1;
        rcnt_d    = rcnt_q + RW'(1);
        if (rcnt_q == ROUND_LAST) begin
          if (last_pt_next) begin
            ena_xor_down_o  = 1'b1;
            data_xor_down_o = {key_q, KW'(0)};
          end
          rcnt_d  = '0;
          state_d = WAIT_PT;
        end
      end

      DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Outputs are held quiet while reset is asserted
    if (reset_i) begin
      block_ready_o   = 1'b0;
      select_o        = 1'b0;
      roundp_o        = '0;
      ena_reg_o       = 1'b0;
      ena_xor_up_o    = 1'b0;
      data_xor_up_o   = '0;
      ena_xor_down_o  = 1'b0;
      data_xor_down_o = '0;
      ena_cipher_o    = 1'b0;
      tag_valid_o     = 1'b0;
      busy_o          = 1'b0;
      done_o          = 1'b0;
    end
  end

endmodule
